simon_data_out: RTL and testbench

- Output-side packetiser for the SIMON64/96 datapath; the transmit counterpart of the input packet loader.
- Takes finished cipher blocks (two N-bit words each) from the round engine and assembles them into output packets: N/2 data bytes, one count byte and one info byte.
- Presents each packet to the host interface with a level-signalled new/ack handshake.
- Packing order and block slots are the mirror image of the input packet format, so a round-tripped packet has an identical layout.

---
 rtl/simon_data_out.sv | 114 +++++++++++
 tb/tb_simon_data_out.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/simon_data_out.sv
// Output packetiser for SIMON64/96: collects finished cipher blocks into
// host packets (data words, count byte, info byte) with a new/ack handshake.
module simon_data_out #(
  parameter int          N    = 32,
  parameter logic [3:0]  MODE = 4'h3
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic                      doneDATA,
  input  logic [1:0][N-1:0]         cipherOUT,
  input  logic [7:0]                infoIN,
  output logic                      loadOUT,
  output logic [(1+N/2):0][7:0]     out_pkt,
  output logic                      out_newPKT,
  input  logic                      out_loadPKT,
  output logic                      out_donePKT,
  output logic                      errOUT
);

  // state   | meaning
  // IDLE    | waiting for a cipher block
  // CAPTURE | block written into its slot, loadOUT pulsed
  // BUILD   | count and info bytes written
  // SEND    | packet offered to host
  // RELEASE | host ack seen, waiting for it to drop
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    BUILD   = 3'd2,
    SEND    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int NB = N / 8;
  localparam int PB = N / 2;

  state_t                   state, state_nxt;
  logic [(1+N/2):0][7:0]    pkt;
  logic                     slot;
  logic [7:0]               cnt;
  logic                     err;
  logic [1:0]               info_q;
  logic                     first_blk;

  // Only a two-block packet with no half already held goes into words 0,1.
  assign first_blk = infoIN[7] & ~slot;

  always_ff @(posedge clk) begin
    if (R) begin
      state  <= IDLE;
      pkt    <= '0;
      slot   <= 1'b0;
      cnt    <= 8'd0;
      err    <= 1'b0;
      info_q <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        CAPTURE: begin
          info_q <= infoIN[7:6];
          if (infoIN[5]) err <= 1'b1;
          if (first_blk) begin
            pkt[0  +: NB] <= cipherOUT[0];
            pkt[NB +: NB] <= cipherOUT[1];
            slot          <= 1'b1;
          end else begin
            pkt[2*NB +: NB] <= cipherOUT[0];
            pkt[3*NB +: NB] <= cipherOUT[1];
            if (!slot) pkt[0 +: 2*NB] <= '0;
          end
        end
        BUILD: begin
          pkt[PB]   <= cnt;
          pkt[PB+1] <= {info_q, 2'b01, MODE};
          slot      <= 1'b0;
        end
        RELEASE: begin
          if (!out_loadPKT) cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    loadOUT     = 1'b0;
    out_newPKT  = 1'b0;
    out_donePKT = 1'b0;
    case (state)
      IDLE: begin
        out_donePKT = ~slot;
        if (doneDATA) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        loadOUT   = 1'b1;
        state_nxt = first_blk ? IDLE : BUILD;
      end
      BUILD: state_nxt = SEND;
      SEND: begin
        out_newPKT = 1'b1;
        if (out_loadPKT) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!out_loadPKT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_pkt = pkt;
  assign errOUT  = err;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for simon_data_out: reset, single/two-block packing,
// backpressure, error flag, mid-packet reset and count wrap.
module tb_simon_data_out;

  localparam int N = 32;

  logic             clk = 1'b0;
  logic             R;
  logic             doneDATA;
  logic [1:0][N-1:0] cipherOUT;
  logic [7:0]       infoIN;
  logic             loadOUT;
  logic [17:0][7:0] out_pkt;
  logic             out_newPKT;
  logic             out_loadPKT;
  logic             out_donePKT;
  logic             errOUT;

  int passed = 0;
  int total  = 0;

  simon_data_out #(.N(N), .MODE(4'h3)) dut (
    .clk        (clk),
    .R          (R),
    .doneDATA   (doneDATA),
    .cipherOUT  (cipherOUT),
    .infoIN     (infoIN),
    .loadOUT    (loadOUT),
    .out_pkt    (out_pkt),
    .out_newPKT (out_newPKT),
    .out_loadPKT(out_loadPKT),
    .out_donePKT(out_donePKT),
    .errOUT     (errOUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word(input int k);
    return out_pkt[k*4 +: 4];
  endfunction

  // Present a block at a negedge and wait for loadOUT; drop doneDATA on it.
  task automatic send_blk(input logic [7:0] info, input logic [31:0] hi,
                          input logic [31:0] lo, output int lat);
    doneDATA  = 1'b1;
    infoIN    = info;
    cipherOUT = {hi, lo};
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (loadOUT) begin lat = k; break; end
    end
    doneDATA = 1'b0;
  endtask

  task automatic wait_pkt(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (out_newPKT) begin lat = k; break; end
    end
  endtask

  task automatic ack();
    out_loadPKT = 1'b1;
    @(negedge clk);
    out_loadPKT = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    R = 1'b1;
    repeat (cycles) @(negedge clk);
    R = 1'b0;
  endtask

  int lat1, lat2, bad;
  logic saw_load, pkt_chg;
  logic [17:0][7:0] snap;

  initial begin
    R = 1'b1; doneDATA = 1'b1; cipherOUT = '0; infoIN = 8'h00; out_loadPKT = 1'b0;

    // Reset held two cycles with doneDATA high
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (loadOUT || out_newPKT || !out_donePKT || errOUT || (|out_pkt)) bad++;
    end
    check("reset_outputs", 64'(bad), 64'd0);
    R = 1'b0; doneDATA = 1'b0;
    @(negedge clk);
    check("idle_done", {63'd0, out_donePKT}, 64'd1);

    // Single block
    send_blk(8'h00, 32'hDEADBEEF, 32'h01234567, lat1);
    check("load_latency", 64'(lat1), 64'd1);
    wait_pkt(lat2);
    check("newpkt_latency", 64'(lat1 + lat2), 64'd3);
    check("single_w0w1", {word(1), word(0)}, 64'd0);
    check("single_w2", 64'(word(2)), 64'h01234567);
    check("single_w3", 64'(word(3)), 64'hDEADBEEF);
    check("single_cnt", 64'(out_pkt[16]), 64'h00);
    check("single_info", 64'(out_pkt[17]), 64'h13);
    ack();
    check("release_newpkt", {63'd0, out_newPKT}, 64'd0);

    // Two-block packet: A then B
    send_blk(8'h80, 32'hAAAA0001, 32'hAAAA0000, lat1);
    repeat (4) @(negedge clk);
    check("two_no_pkt_after_a", {62'd0, out_newPKT, out_donePKT}, 64'd0);
    send_blk(8'h80, 32'hBBBB0001, 32'hBBBB0000, lat1);
    wait_pkt(lat2);
    check("two_newpkt_latency", 64'(lat1 + lat2), 64'd3);
    check("two_w0w1", {word(1), word(0)}, 64'hAAAA0001_AAAA0000);
    check("two_w2w3", {word(3), word(2)}, 64'hBBBB0001_BBBB0000);
    check("two_cnt", 64'(out_pkt[16]), 64'h01);
    check("two_info", 64'(out_pkt[17]), 64'h93);

    // Backpressure: next block held while the host sits on the packet
    doneDATA = 1'b1; infoIN = 8'h00; cipherOUT = {32'hCCCC0001, 32'hCCCC0000};
    snap = out_pkt; saw_load = 1'b0; pkt_chg = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (loadOUT) saw_load = 1'b1;
      if (out_pkt !== snap) pkt_chg = 1'b1;
    end
    check("bp_no_load", {63'd0, saw_load}, 64'd0);
    check("bp_pkt_stable", {63'd0, pkt_chg}, 64'd0);
    check("bp_newpkt_held", {63'd0, out_newPKT}, 64'd1);
    ack();
    lat1 = 0;
    for (int k = 1; k <= 10; k++) begin
      if (loadOUT) begin lat1 = k; break; end
      @(negedge clk);
    end
    check("bp_captured", 64'(lat1 != 0), 64'd1);
    doneDATA = 1'b0;
    wait_pkt(lat2);
    check("bp_words", {word(3), word(2), word(1), word(0)} == {32'hCCCC0001, 32'hCCCC0000, 64'd0} ? 64'd1 : 64'd0, 64'd1);
    check("bp_cnt", 64'(out_pkt[16]), 64'h02);
    ack();

    // Error flag
    send_blk(8'h20, 32'h0, 32'h5, lat1);
    wait_pkt(lat2);
    check("err_set", {63'd0, errOUT}, 64'd1);
    check("err_info", 64'(out_pkt[17]), 64'h13);
    check("err_data", 64'(word(2)), 64'h5);
    ack();
    send_blk(8'h00, 32'h0, 32'h6, lat1);
    wait_pkt(lat2);
    check("err_sticky", {63'd0, errOUT}, 64'd1);
    ack();

    // Reset between the two halves of a two-block packet
    send_blk(8'h80, 32'h1, 32'h2, lat1);
    @(negedge clk);
    check("half_pending", {63'd0, out_donePKT}, 64'd0);
    do_reset(1);
    check("rst_mid_done", {63'd0, out_donePKT}, 64'd1);
    check("rst_mid_err", {63'd0, errOUT}, 64'd0);
    check("rst_mid_pkt", 64'(|out_pkt), 64'd0);
    send_blk(8'h00, 32'h7, 32'h8, lat1);
    wait_pkt(lat2);
    check("rst_mid_cnt", 64'(out_pkt[16]), 64'h00);
    check("rst_mid_w0", 64'(word(0)), 64'h0);
    ack();

    // Count wrap over 257 packets
    do_reset(1);
    bad = 0;
    for (int i = 0; i < 257; i++) begin
      send_blk(8'h00, 32'(i), ~32'(i), lat1);
      wait_pkt(lat2);
      check("wrap_cnt", 64'(out_pkt[16]), 64'(i % 256));
      ack();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
